// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter and the
// hazard/forwarding logic that reuses the same register-file widths.
package rf_wb_arbiter_pkg;

    typedef enum logic {
        S_NORM  = 1'b0,
        S_BOOST = 1'b1
    } wb_state_e;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;

    localparam logic [RF_AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rf_wb_arbiter.sv
// Two-requester arbiter for the register file's single write port:
// fixed priority to requester 0 with a starvation boost for requester 1.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int AW         = RF_AW,
    parameter int DW         = RF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic [AW-1:0] A3,
    output logic [DW-1:0] WD3,
    output logic          WE3,
    output logic          boost
);

    localparam int            CW       = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(STARVE_MAX);
    localparam logic [CW-1:0] CNT_TRIG = CW'(STARVE_MAX - 1);

    wb_state_e     r_state;
    wb_state_e     w_state_nxt;
    logic [CW-1:0] r_starve_cnt;
    logic [CW-1:0] w_starve_nxt;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_gnt_any;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          w_we_nxt;

    logic          r_we;
    logic [AW-1:0] r_a3;
    logic [DW-1:0] r_wd3;

    // Grants are gated by reset so nothing is handshaked while the port is held clear.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst) begin
            if (r_state == S_BOOST) begin
                w_gnt1 = req1_valid;
                w_gnt0 = req0_valid && !req1_valid;
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid && !req0_valid;
            end
        end
    end

    assign w_gnt_any = w_gnt0 || w_gnt1;
    assign w_addr    = w_gnt1 ? req1_addr : req0_addr;
    assign w_data    = w_gnt1 ? req1_data : req0_data;
    assign w_we_nxt  = w_gnt_any && (w_addr != AW'(REG_ZERO));

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;

        if (!req1_valid || w_gnt1) begin
            w_starve_nxt = '0;
        end else if (r_starve_cnt != CNT_SAT) begin
            w_starve_nxt = r_starve_cnt + 1'b1;
        end

        case (r_state)
            S_NORM: begin
                if (req1_valid && !w_gnt1 && (r_starve_cnt == CNT_TRIG)) begin
                    w_state_nxt = S_BOOST;
                end
            end
            S_BOOST: begin
                if (w_gnt1 || !req1_valid) begin
                    w_state_nxt = S_NORM;
                end
            end
            default: w_state_nxt = S_NORM;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_NORM;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // Address/data follow every grant, including $0 writes; only the enable is filtered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we  <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
        end else begin
            r_we <= w_we_nxt;
            if (w_gnt_any) begin
                r_a3  <= w_addr;
                r_wd3 <= w_data;
            end
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign A3         = r_a3;
    assign WD3        = r_wd3;
    assign WE3        = r_we;
    assign boost      = (r_state == S_BOOST);

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (A3/WD3/WE3) between two writeback requesters.
- Requester 0 is the primary source (ALU/load result); requester 1 is the secondary source (multi-cycle mul/div unit).
- Arbitration is fixed-priority with a starvation guard. The selected write is registered and presented to the register file one cycle after acceptance.
- Writes to $0 are filtered out, which enforces the MIPS zero register.

Parameters:
- STARVE_MAX, 4, consecutive cycles requester 1 may be denied while valid before it is boosted (legal range 1..15).
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a write.
- req0_addr  in  AW  destination register for requester 0.
- req0_data  in  DW  write data for requester 0.
- req0_ready  out  1  requester 0's write is accepted this cycle.
- req1_valid  in  1  requester 1 has a write.
- req1_addr  in  AW  destination register for requester 1.
- req1_data  in  DW  write data for requester 1.
- req1_ready  out  1  requester 1's write is accepted this cycle.
- A3  out  AW  register file write address (registered).
- WD3  out  DW  register file write data (registered).
- WE3  out  1  register file write enable (registered, one-cycle pulse per write).
- boost  out  1  high while the FSM is in S_BOOST; for debug/coverage.

Behaviour:
- Reset (rst=0, asynchronous):
  - A3=0, WD3=0, WE3=0.
  - FSM=S_NORM, starve_cnt=0.
  - Any write registered but not yet presented is discarded.
- Handshake:
  - A transfer occurs when valid and ready are both high at a rising edge.
  - ready is combinational from the valid inputs and the FSM state only; it never depends on data or addr.
  - At most one ready is high per cycle.
  - A requester keeps valid/addr/data stable until it sees ready.
- Grant:
  - In S_NORM: req0 wins if valid; otherwise req1 wins if valid.
  - In S_BOOST: req1 wins if valid; otherwise req0 wins if valid.
  - Exactly one of two valid requesters is granted; the other waits with ready=0.
- Output stage, on a grant at edge N:
  - At edge N: A3<=addr, WD3<=data, WE3<=(addr!=0).
  - WE3 is high during the cycle after edge N; the register file captures at edge N+1.
  - With no grant: WE3<=0, and A3/WD3 hold their previous values.
  - Sustained throughput is one write per cycle.
- $0 filter:
  - A write to addr 0 is still handshaked (ready=1) and still counts as a grant.
  - WE3 stays 0 for that write.
- Starvation counter (starve_cnt, width ceil(log2(STARVE_MAX+1))):
  - Increments when req1_valid=1 and req1 is not granted.
  - Clears when req1 is granted or req1_valid=0.
  - Saturates at STARVE_MAX.
- FSM:
  - S_NORM -> S_BOOST when req1 is denied at an edge and starve_cnt==STARVE_MAX-1.
  - S_BOOST -> S_NORM when req1 is granted, or when req1_valid=0 (requester withdrew).
  - No other transitions.
- Boost grant order: a boost grants req1 on the first cycle in S_BOOST, even if req0 is valid. That cycle req0_ready=0.
- Worst-case latency: a continuously valid req1 is granted within STARVE_MAX+1 cycles of first asserting valid.
- Simultaneous events:
  - If both requesters target the same address in consecutive grants, the later grant's data ends in the register file. No merging or reordering.
  - A reset asserted mid-burst clears WE3 immediately, without waiting for a clock edge.
  - After reset deassertion the first edge may already grant.

Decomposition:
- Shared package holds:
  - FSM state encoding: S_NORM=1'b0, S_BOOST=1'b1.
  - REG_ZERO=5'd0.
  - Default widths (AW=5, DW=32), for reuse by the hazard/forwarding logic.
- No sub-module: grant logic, counter, FSM and output register are one block, roughly 150 lines.

Test Plan:
1. Reset: hold rst=0 with both requesters valid -> WE3=0, A3=0, WD3=0, both ready=0 (no grant in reset), boost=0. Release rst -> first edge grants req0.
2. Single requester: req0 valid addr=5 data=0xDEADBEEF for one cycle -> req0_ready=1 that cycle; next cycle WE3=1, A3=5, WD3=0xDEADBEEF; following cycle WE3=0.
3. $0 filter: req1 valid addr=0 data=0x12345678 alone -> req1_ready=1; next cycle WE3=0.
4. Starvation, STARVE_MAX=4: req0 and req1 continuously valid (req1 addr=9 data=0xA5A5A5A5) ->
   - req0 granted for 4 cycles;
   - boost=1 on the 5th cycle, with req1_ready=1 and req0_ready=0;
   - next cycle WE3=1, A3=9, WD3=0xA5A5A5A5;
   - FSM returns to S_NORM and req0 is granted again.
5. Boost withdrawal: enter S_BOOST, then drop req1_valid before it is granted -> next edge FSM returns to S_NORM, starve_cnt=0, req0 granted.
6. Reset mid-stream: back-to-back req0 writes, assert rst while WE3=1 -> WE3 falls to 0 asynchronously; after release, FSM=S_NORM and starve_cnt=0.
